avmm_burst_writer: RTL and testbench

Downstream stage of the element packer. Consumes packed beats (data, byte strobes, last) and writes them to memory as Avalon-MM write bursts starting at a programmed base address. An internal beat FIFO lets a full-length burst be announced before it is streamed. A partial final burst is flushed when the last beat arrives.

---
 rtl/avmm_burst_writer.sv | 133 +++++++++++++
 tb/tb_avmm_burst_writer.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_burst_writer.sv
// avmm_burst_writer: writes packed beats to memory as Avalon-MM write bursts from a base address.
//   clk, rst_n        clock, asynchronous active-low reset
//   start, base_addr  start pulse (honoured only when idle) and beat-aligned byte address
//   s_*               beat stream in (valid/ready/data/strb/last)
//   avm_*             Avalon-MM burst write master
//   busy, done        transfer in progress, one-cycle completion pulse
//   beats_written     beats accepted by the slave in the current or last transfer
module avmm_burst_writer #(
    parameter int ADDR_W    = 32,
    parameter int BEAT_W    = 128,
    parameter int MAX_BURST = 8,
    parameter int BC_W      = $clog2(MAX_BURST) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BEAT_W-1:0]   s_data,
    input  logic [BEAT_W/8-1:0] s_strb,
    input  logic                s_last,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_write,
    output logic [BEAT_W-1:0]   avm_writedata,
    output logic [BEAT_W/8-1:0] avm_byteenable,
    output logic [BC_W-1:0]     avm_burstcount,
    input  logic                avm_waitrequest,
    output logic                busy,
    output logic                done,
    output logic [31:0]         beats_written
);
    localparam int SW = BEAT_W / 8;
    localparam int PW = $clog2(MAX_BURST);

    typedef enum logic [1:0] {IDLE, FILL, BURST, DONE} state_t;

    state_t            state;
    logic [BEAT_W-1:0] mem_data [MAX_BURST];
    logic [SW-1:0]     mem_strb [MAX_BURST];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [BC_W-1:0]   count, count_nxt, remaining;
    logic [ADDR_W-1:0] cur_addr;
    logic              last_in, full, push, pop;

    assign full      = count == BC_W'(MAX_BURST);
    assign s_ready   = busy && !full && !last_in;
    assign push      = s_valid && s_ready;
    assign pop       = avm_write && !avm_waitrequest;
    assign count_nxt = count + BC_W'(push) - BC_W'(pop);
    // The head entry only moves on a pop, so data/byteenable hold during waitrequest.
    assign avm_writedata  = avm_write ? mem_data[rd_ptr] : '0;
    assign avm_byteenable = avm_write ? mem_strb[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= s_data;
            mem_strb[wr_ptr] <= s_strb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            remaining      <= '0;
            cur_addr       <= '0;
            last_in        <= 1'b0;
            avm_address    <= '0;
            avm_write      <= 1'b0;
            avm_burstcount <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            beats_written  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr        <= rd_ptr + PW'(1);
                beats_written <= beats_written + 32'd1;
            end
            count <= count_nxt;
            if (push && s_last) last_in <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr      <= base_addr;
                        beats_written <= '0;
                        busy          <= 1'b1;
                        state         <= FILL;
                    end
                end
                FILL: begin
                    // A full FIFO issues a MAX_BURST burst; a partial one only once the last beat is in.
                    if (full || (last_in && count != '0)) begin
                        avm_write      <= 1'b1;
                        avm_address    <= cur_addr;
                        avm_burstcount <= count;
                        remaining      <= count;
                        state          <= BURST;
                    end else if (last_in) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                BURST: begin
                    if (pop) begin
                        remaining <= remaining - BC_W'(1);
                        if (remaining == BC_W'(1)) begin
                            avm_write <= 1'b0;
                            cur_addr  <= cur_addr + ADDR_W'(avm_burstcount) * ADDR_W'(SW);
                            if (last_in && count_nxt == '0) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= DONE;
                            end else begin
                                state <= FILL;
                            end
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    last_in <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avmm_burst_writer.sv
// tb_avmm_burst_writer: randomized self-checking bench for avmm_burst_writer against a burst-splitting model.
module tb_avmm_burst_writer;
    localparam int MB = 8;
    localparam int SW = 16;

    typedef struct packed {
        logic [31:0]  addr;
        logic [3:0]   bc;
        logic [127:0] data;
        logic [15:0]  strb;
    } beat_t;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [31:0]  base_addr = '0;
    logic         s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [127:0] s_data = '0;
    logic [15:0]  s_strb = '0;
    logic [31:0]  avm_address;
    logic         avm_write, avm_waitrequest;
    logic [127:0] avm_writedata;
    logic [15:0]  avm_byteenable;
    logic [3:0]   avm_burstcount;
    logic         busy, done;
    logic [31:0]  beats_written;

    avmm_burst_writer #(.ADDR_W(32), .BEAT_W(128), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_strb(s_strb), .s_last(s_last),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done), .beats_written(beats_written)
    );

    always #5 clk = ~clk;

    beat_t        obs_q[$], exp_q[$];
    logic [127:0] src_data[$];
    logic [15:0]  src_strb[$];
    int checks = 0, errors = 0;
    int obs_base = 0, done_cnt = 0, stall_cycles = 0, stall_viol = 0, xfer_done0 = 0;
    int stall_tab[64];
    bit stall_rand = 1'b0;
    int stall_cnt = 0, last_idx = -1, drv_idx = 0;
    beat_t cur, snap;
    bit prev_stall = 1'b0;

    // Monitor: records every beat the slave accepts and any output change during a stall.
    initial forever begin
        @(negedge clk);
        cur = '{avm_address, avm_burstcount, avm_writedata, avm_byteenable};
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (prev_stall && (!avm_write || cur !== snap)) stall_viol++;
            if (avm_write && !avm_waitrequest) obs_q.push_back(cur);
            if (avm_write && avm_waitrequest) stall_cycles++;
            if (done) done_cnt++;
            prev_stall = avm_write && avm_waitrequest;
            snap = cur;
        end
    end

    // Slave: stalls either randomly or per sent-beat index from stall_tab.
    initial begin
        avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!avm_write) begin
                avm_waitrequest = 1'b0;
                stall_cnt = 0;
                last_idx = -1;
            end else if (stall_rand) begin
                avm_waitrequest = ($urandom_range(0, 2) == 0);
            end else begin
                drv_idx = obs_q.size() - obs_base;
                if (drv_idx != last_idx) begin
                    stall_cnt = 0;
                    last_idx = drv_idx;
                end
                avm_waitrequest = 1'b0;
                if (drv_idx < 64) begin
                    if (stall_cnt < stall_tab[drv_idx]) avm_waitrequest = 1'b1;
                end
                if (avm_waitrequest) stall_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic beat_t got(input int i);
        if (obs_base + i < obs_q.size()) return obs_q[obs_base + i];
        return 'x;
    endfunction

    // Model: beat i belongs to burst i/MB, which starts at base + burst*MB*SW and holds min(MB, remaining) beats.
    task automatic gen_beats(input logic [31:0] base, input int n, input int strb_mode);
        src_data.delete();
        src_strb.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [127:0] d;
            logic [15:0]  st;
            int k, rem;
            d = {$urandom, $urandom, $urandom, $urandom};
            if (strb_mode == 2) st = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            else st = (strb_mode == 1 && i == n - 1) ? 16'h00FF : 16'hFFFF;
            k = i / MB;
            rem = n - k * MB;
            src_data.push_back(d);
            src_strb.push_back(st);
            exp_q.push_back('{base + 32'(k * MB * SW), 4'(rem < MB ? rem : MB), d, st});
        end
    endtask

    task automatic pulse_start(input logic [31:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beats(input bit gaps);
        for (int i = 0; i < src_data.size(); i++) begin
            bit acc;
            int t;
            if (gaps) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            s_valid = 1'b1;
            s_data = src_data[i];
            s_strb = src_strb[i];
            s_last = (i == src_data.size() - 1);
            acc = 1'b0;
            t = 0;
            while (!acc && t < 1000) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL send_beat %0d s_ready stuck at 0, required 1", i);
                s_valid = 1'b0;
                s_last = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 2000) begin @(posedge clk); t++; end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_transfer(input logic [31:0] base, input int n, input int strb_mode,
                                input bit gaps, input bit extra_start);
        gen_beats(base, n, strb_mode);
        obs_base = obs_q.size();
        xfer_done0 = done_cnt;
        pulse_start(base);
        if (extra_start) begin
            fork
                send_beats(gaps);
                begin
                    repeat (6) begin @(posedge clk); #1; end
                    start = 1'b1;
                    base_addr = 32'hDEAD0000;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            join
        end else begin
            send_beats(gaps);
        end
        wait_done(xfer_done0);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({avm_write, busy, s_ready, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b need 0000", {avm_write, busy, s_ready, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({avm_address, avm_burstcount, beats_written} !== '0) begin
            errors++;
            $display("FAIL reset_regs got %h need 0", {avm_address, avm_burstcount, beats_written});
        end
        checks++;
        if ({avm_writedata, avm_byteenable, avm_write, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h need 0", {avm_writedata, avm_byteenable});
        end
    endtask

    task automatic test_full_bursts();
        run_transfer(32'h1000, 16, 0, 1'b0, 1'b0);
        checks++;
        if (obs_q.size() - obs_base !== 16) begin
            errors++;
            $display("FAIL full_count got %0d need 16", obs_q.size() - obs_base);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL full_beat %0d got %h need %h", i, got(i), exp_q[i]);
            end
        end
        checks++;
        if (got(8).addr !== 32'h1080 || got(8).bc !== 4'd8) begin
            errors++;
            $display("FAIL full_second_burst got %h/%0d need 1080/8", got(8).addr, got(8).bc);
        end
        checks++;
        if (beats_written !== 32'd16) begin
            errors++;
            $display("FAIL full_beats_written got %0d need 16", beats_written);
        end
        checks++;
        if (done_cnt - xfer_done0 !== 1) begin
            errors++;
            $display("FAIL full_done got %0d pulses need 1", done_cnt - xfer_done0);
        end
    endtask

    task automatic test_partial();
        run_transfer(32'h1000, 10, 1, 1'b0, 1'b0);
        checks++;
        if (obs_q.size() - obs_base !== 10) begin
            errors++;
            $display("FAIL partial_count got %0d need 10", obs_q.size() - obs_base);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL partial_beat %0d got %h need %h", i, got(i), exp_q[i]);
            end
        end
        checks++;
        if (got(9).strb !== 16'h00FF || got(9).bc !== 4'd2 || got(9).addr !== 32'h1080) begin
            errors++;
            $display("FAIL partial_tail got %h need 1080/2/00ff", got(9));
        end
    endtask

    task automatic test_stall();
        int s0, v0;
        stall_tab[0] = 5;
        stall_tab[4] = 3;
        s0 = stall_cycles;
        v0 = stall_viol;
        run_transfer(32'h4000, 8, 2, 1'b0, 1'b0);
        stall_tab[0] = 0;
        stall_tab[4] = 0;
        checks++;
        if (obs_q.size() - obs_base !== 8) begin
            errors++;
            $display("FAIL stall_count got %0d need 8", obs_q.size() - obs_base);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_beat %0d got %h need %h", i, got(i), exp_q[i]);
            end
        end
        checks++;
        if (stall_cycles - s0 !== 8) begin
            errors++;
            $display("FAIL stall_cycles got %0d need 8", stall_cycles - s0);
        end
        checks++;
        if (stall_viol - v0 !== 0) begin
            errors++;
            $display("FAIL stall_hold got %0d changes need 0", stall_viol - v0);
        end
    endtask

    task automatic test_wrap();
        run_transfer(32'hFFFFFFF0, 1, 0, 1'b0, 1'b0);
        checks++;
        if (obs_q.size() - obs_base !== 1 || got(0) !== exp_q[0]) begin
            errors++;
            $display("FAIL wrap_single got %h need %h", got(0), exp_q[0]);
        end
        checks++;
        if (got(0).addr !== 32'hFFFFFFF0 || got(0).bc !== 4'd1 || done_cnt - xfer_done0 !== 1) begin
            errors++;
            $display("FAIL wrap_burst got %h/%0d done %0d need fffffff0/1 done 1",
                     got(0).addr, got(0).bc, done_cnt - xfer_done0);
        end
        run_transfer(32'h0, 3, 0, 1'b1, 1'b0);
        checks++;
        if (obs_q.size() - obs_base !== 3) begin
            errors++;
            $display("FAIL wrap_next_count got %0d need 3", obs_q.size() - obs_base);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_next_beat %0d got %h need %h", i, got(i), exp_q[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int ob;
        ob = obs_q.size();
        s_valid = 1'b1;
        s_data = {4{32'hBAD0BAD0}};
        s_strb = 16'hFFFF;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready got s_ready=%b busy=%b need 0 0", s_ready, busy);
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        run_transfer(32'h3000, 12, 2, 1'b1, 1'b1);
        checks++;
        if (obs_q.size() - ob !== 12) begin
            errors++;
            $display("FAIL ignore_count got %0d need 12", obs_q.size() - ob);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL ignore_beat %0d got %h need %h", i, got(i), exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic pre;
        int t = 0;
        gen_beats(32'h5000, 8, 0);
        obs_base = obs_q.size();
        pulse_start(32'h5000);
        send_beats(1'b0);
        while (obs_q.size() - obs_base < 3 && t < 300) begin @(posedge clk); t++; end
        @(negedge clk); #1;
        pre = avm_write;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pre !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre avm_write got %b need 1", pre);
        end
        checks++;
        if ({avm_write, busy, s_ready, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid_ctrl got %b need 0000", {avm_write, busy, s_ready, done});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({avm_address, avm_burstcount, beats_written, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_idle got %h need 0", {avm_address, avm_burstcount, beats_written, busy});
        end
        run_transfer(32'h2000, 4, 0, 1'b0, 1'b0);
        checks++;
        if (obs_q.size() - obs_base !== 4 || beats_written !== 32'd4) begin
            errors++;
            $display("FAIL reset_mid_after got %0d beats bw=%0d need 4", obs_q.size() - obs_base, beats_written);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_mid_beat %0d got %h need %h", i, got(i), exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int v0;
        stall_rand = 1'b1;
        v0 = stall_viol;
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 30);
            run_transfer($urandom & 32'hFFFFFFF0, n, 2, 1'b1, 1'b0);
            checks++;
            if (obs_q.size() - obs_base !== n || beats_written !== 32'(n)) begin
                errors++;
                $display("FAIL rand_count run %0d got %0d bw=%0d need %0d", r, obs_q.size() - obs_base, beats_written, n);
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got(i) !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_beat run %0d beat %0d got %h need %h", r, i, got(i), exp_q[i]);
                end
            end
        end
        stall_rand = 1'b0;
        checks++;
        if (stall_viol - v0 !== 0) begin
            errors++;
            $display("FAIL rand_hold got %0d changes need 0", stall_viol - v0);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) stall_tab[i] = 0;
        repeat (3) @(posedge clk);
        test_reset();
        test_full_bursts();
        test_partial();
        test_stall();
        test_wrap();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
